mem_phase_sequencer: RTL and testbench

- Sequences the node's eight routing phase engines, in order: learnCosts, amISink, amIDestination, fixSinkList, neighborSinkInOtherCluster, findMyBest, betterNeighborsInMyCluster, winnerPolicy/selectMyAction/reward.
- Gives one phase at a time exclusive use of the single shared 11-bit-address / 16-bit-data node memory port.
- Replaces the done-flag priority chain with an explicit start/done handshake and a per-run phase skip mask.
- Sits between the phase engines and the external memory interface.

---
 rtl/mem_phase_sequencer_pkg.sv | 23 ++
 rtl/mem_phase_sequencer_if.sv | 27 ++
 rtl/mem_phase_sequencer_next_phase_find.sv | 20 ++
 rtl/mem_phase_sequencer.sv | 83 ++++++++
 tb/tb_mem_phase_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_phase_sequencer_pkg.sv
// mem_phase_sequencer_pkg: shared widths, FSM encodings and phase indices for the phase sequencer.
package mem_phase_sequencer_pkg;
  localparam int NUM_PHASES = 8;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  typedef logic [2:0] phase_idx_t;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] RUN = 3'd2;
  localparam logic [2:0] NEXT = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;
  localparam phase_idx_t PH_LEARN = 3'd0;
  localparam phase_idx_t PH_SINK = 3'd1;
  localparam phase_idx_t PH_DEST = 3'd2;
  localparam phase_idx_t PH_FIX_SINK = 3'd3;
  localparam phase_idx_t PH_NBR_OTHER = 3'd4;
  localparam phase_idx_t PH_BEST = 3'd5;
  localparam phase_idx_t PH_BETTER_NBR = 3'd6;
  localparam phase_idx_t PH_ACTION = 3'd7;
  function automatic logic [NUM_PHASES-1:0] onehot(input phase_idx_t idx);
    return NUM_PHASES'(1) << idx;
  endfunction
endpackage

// File: rtl/mem_phase_sequencer_if.sv
// mem_phase_sequencer_if: phase-engine handshake, per-phase memory requests and the shared memory port.
interface mem_phase_sequencer_if;
  import mem_phase_sequencer_pkg::*;
  logic en;
  logic [NUM_PHASES-1:0] phase_mask;
  logic [NUM_PHASES-1:0] phase_done;
  logic [NUM_PHASES-1:0] phase_start;
  logic [NUM_PHASES*ADDR_W-1:0] ph_addr;
  logic [NUM_PHASES-1:0] ph_wr_en;
  logic [NUM_PHASES*DATA_W-1:0] ph_wdata;
  logic [ADDR_W-1:0] address;
  logic wr_en;
  logic [DATA_W-1:0] mem_data_in;
  logic [NUM_PHASES-1:0] grant;
  phase_idx_t cur_phase;
  logic busy;
  logic done;
  logic timeout_err;
  modport slave (
    input en, phase_mask, phase_done, ph_addr, ph_wr_en, ph_wdata,
    output phase_start, address, wr_en, mem_data_in, grant, cur_phase, busy, done, timeout_err
  );
  modport master (
    output en, phase_mask, phase_done, ph_addr, ph_wr_en, ph_wdata,
    input phase_start, address, wr_en, mem_data_in, grant, cur_phase, busy, done, timeout_err
  );
endinterface

// File: rtl/mem_phase_sequencer_next_phase_find.sv
// mem_phase_sequencer_next_phase_find: lowest set mask bit above floor_idx (or at it when incl is set).
module mem_phase_sequencer_next_phase_find
  import mem_phase_sequencer_pkg::*;
(
  input  logic [NUM_PHASES-1:0] mask,
  input  phase_idx_t            floor_idx,
  input  logic                  incl,
  output phase_idx_t            idx,
  output logic                  found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = NUM_PHASES - 1; i >= 0; i--)
      if (mask[i] && (i > int'(floor_idx) || (incl && i == int'(floor_idx)))) begin
        idx = phase_idx_t'(i);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/mem_phase_sequencer.sv
// mem_phase_sequencer: runs masked phase engines in order with exclusive use of the shared memory port.
// Define PHASE_TIMEOUT_EN to add the per-phase watchdog and sticky timeout_err.
module mem_phase_sequencer
  import mem_phase_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input logic clock,
  input logic nrst,
  mem_phase_sequencer_if.slave bus
);
  logic [2:0] state_q, state_d;
  phase_idx_t cur_q, cur_d, find_idx, find_floor;
  logic [NUM_PHASES-1:0] mask_q, mask_d, grant_q, grant_d, start_q, start_d, find_mask;
  logic done_q, done_d, find_found, find_incl, search, cur_done, tout_hit, leave_run;
  mem_phase_sequencer_next_phase_find u_find (
    .mask(find_mask), .floor_idx(find_floor), .incl(find_incl), .idx(find_idx), .found(find_found)
  );
  always_comb begin
    find_mask = state_q == IDLE ? bus.phase_mask : mask_q;
    find_floor = state_q == IDLE ? PH_LEARN : cur_q;
    find_incl = state_q == IDLE;
    search = state_q == IDLE ? bus.en : state_q == NEXT;
    cur_done = bus.phase_done[cur_q];
    leave_run = cur_done || tout_hit;
    mask_d = state_q == IDLE && bus.en ? bus.phase_mask : mask_q;
    cur_d = search && find_found ? find_idx : cur_q;
    start_d = search && find_found ? onehot(find_idx) : '0;
    done_d = search && !find_found;
    grant_d = search ? start_d : (state_q == START || (state_q == RUN && !leave_run)) ? grant_q : '0;
    state_d = search ? (find_found ? START : FINISH)
            : state_q == START ? RUN
            : state_q == RUN ? (leave_run ? NEXT : RUN)
            : IDLE;
  end
  always_ff @(posedge clock or negedge nrst)
    if (!nrst) begin
      state_q <= IDLE;
      cur_q <= '0;
      mask_q <= '0;
      grant_q <= '0;
      start_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      mask_q <= mask_d;
      grant_q <= grant_d;
      start_q <= start_d;
      done_q <= done_d;
    end
`ifdef PHASE_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic tout_q, tout_d;
  // the flag rises as the count reaches the limit; the forced exit follows a cycle later, like phase_done
  always_comb begin
    cnt_d = state_q == START ? '0 : state_q == RUN ? cnt_q + 16'd1 : cnt_q;
    tout_hit = state_q == RUN && cnt_q == 16'(TIMEOUT_CYC - 1);
    tout_d = state_q == IDLE && bus.en ? 1'b0
           : tout_q | (state_q == RUN && !cur_done && cnt_d == 16'(TIMEOUT_CYC - 1));
  end
  always_ff @(posedge clock or negedge nrst)
    if (!nrst) begin
      cnt_q <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tout_q <= tout_d;
    end
  assign bus.timeout_err = tout_q;
`else
  assign tout_hit = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
  assign bus.phase_start = start_q;
  assign bus.grant = grant_q;
  assign bus.cur_phase = cur_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.address = |grant_q ? bus.ph_addr[cur_q*ADDR_W +: ADDR_W] : '0;
  assign bus.wr_en = |grant_q ? bus.ph_wr_en[cur_q] : 1'b0;
  assign bus.mem_data_in = |grant_q ? bus.ph_wdata[cur_q*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_mem_phase_sequencer.sv
// tb_mem_phase_sequencer: scoreboarded bench for the phase sequencer; phase engines answer 5 cycles after start.
module tb_mem_phase_sequencer;
  import mem_phase_sequencer_pkg::*;
  logic clock = 1'b0;
  logic nrst = 1'b0;
  always #5 clock = ~clock;
  mem_phase_sequencer_if bus();
  mem_phase_sequencer #(.TIMEOUT_CYC(16)) dut (.clock(clock), .nrst(nrst), .bus(bus));
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e_cyc, done_cyc;
  int st_cyc[8];
  int exp_q[$];
  logic [7:0] resp_done = 8'h00;
  logic [7:0] stray_done = 8'h00;
  logic [7:0] hang = 8'h00;
  logic [7:0] grant_seen, start_seen;
  logic [10:0] a[8];
  logic [15:0] d[8];
  logic [7:0] w;
  assign bus.phase_done = resp_done | stray_done;
  assign bus.ph_wr_en = w;
  for (genvar g = 0; g < 8; g++) begin : pk
    assign bus.ph_addr[g*11 +: 11] = a[g];
    assign bus.ph_wdata[g*16 +: 16] = d[g];
  end
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int idx_of(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  // phase engine model: done pulse in the 5th cycle after its start, unless hung
  initial begin
    int due, pidx;
    bit pend;
    pend = 0;
    due = 0;
    pidx = 0;
    forever begin
      @(negedge clock);
      resp_done = 8'h00;
      if (!nrst) pend = 0;
      else begin
        if (pend && cyc == due) begin
          resp_done = 8'(1) << pidx;
          pend = 0;
        end
        if (bus.phase_start != 8'h00 && (bus.phase_start & hang) == 8'h00) begin
          pend = 1;
          pidx = idx_of(bus.phase_start);
          due = cyc + 5;
        end
      end
    end
  end

  // monitor: port mux / one-hot grant every cycle, start and done events against the scoreboard
  initial forever begin
    int gi, ev, ex;
    logic [10:0] ea;
    logic ew;
    logic [15:0] ed;
    @(negedge clock);
    if (nrst) begin
      grant_seen |= bus.grant;
      start_seen |= bus.phase_start;
      checks++;
      if ((bus.grant & (bus.grant - 8'd1)) != 8'd0) begin
        failures++;
        $display("FAIL grant_onehot got=%b want=at most one bit", bus.grant);
      end
      gi = idx_of(bus.grant);
      ea = bus.grant == 8'h00 ? 11'h0 : a[gi];
      ew = bus.grant == 8'h00 ? 1'b0 : w[gi];
      ed = bus.grant == 8'h00 ? 16'h0 : d[gi];
      checks++;
      if (bus.address !== ea || bus.wr_en !== ew || bus.mem_data_in !== ed
          || (bus.grant != 8'h00 && bus.cur_phase !== 3'(gi))) begin
        failures++;
        $display("FAIL port_mux grant=%b got addr=%h wr=%b data=%h cur=%0d want addr=%h wr=%b data=%h cur=%0d",
                 bus.grant, bus.address, bus.wr_en, bus.mem_data_in, bus.cur_phase, ea, ew, ed, gi);
      end
      if (bus.phase_start != 8'h00 || bus.done === 1'b1) begin
        ev = bus.done === 1'b1 ? 8 : idx_of(bus.phase_start);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_extra got=%0d want=no event", ev);
        end else begin
          ex = exp_q.pop_front();
          if (ev != ex || (ev < 8 && bus.phase_start !== 8'(1) << ev) || (ev == 8 && bus.phase_start !== 8'h00)) begin
            failures++;
            $display("FAIL scoreboard_event got=%0d start=%b want=%0d", ev, bus.phase_start, ex);
          end
        end
        if (ev < 8) st_cyc[ev] = cyc; else done_cyc = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic push_model(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) exp_q.push_back(i);
    exp_q.push_back(8);
  endtask

  task automatic run_en(input logic [7:0] m);
    @(negedge clock);
    bus.phase_mask = m;
    bus.en = 1'b1;
    e_cyc = cyc + 1;
    @(negedge clock);
    bus.en = 1'b0;
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    #1;
    checks++;
    if (bus.done !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL wait_done got done=%b pending=%0d want done=1 pending=0", bus.done, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_grant(input logic [7:0] g);
    int n = 0;
    while (bus.grant !== g && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (bus.grant !== g) begin
      failures++;
      $display("FAIL wait_grant got=%b want=%b", bus.grant, g);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks += 7;
    if (bus.grant !== 8'h00) begin failures++; $display("FAIL rst_grant got=%b want=0", bus.grant); end
    if (bus.phase_start !== 8'h00) begin failures++; $display("FAIL rst_start got=%b want=0", bus.phase_start); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b want=0", bus.done); end
    if (bus.cur_phase !== 3'd0) begin failures++; $display("FAIL rst_cur got=%0d want=0", bus.cur_phase); end
    if ({bus.address, bus.wr_en, bus.mem_data_in} !== 28'h0) begin
      failures++; $display("FAIL rst_port got=%h want=0", {bus.address, bus.wr_en, bus.mem_data_in});
    end
    if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL rst_tout got=%b want=0", bus.timeout_err); end
    nrst = 1'b1;
  endtask

  task automatic test_full_run();
    push_model(8'hFF);
    run_en(8'hFF);
    checks += 2;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL full_busy_start got=%b want=1", bus.busy); end
    if (st_cyc[0] != e_cyc) begin failures++; $display("FAIL full_first_start got=%0d want=%0d", st_cyc[0], e_cyc); end
    wait_done(100);
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (st_cyc[i] - st_cyc[i-1] != 7) begin
        failures++; $display("FAIL full_gap%0d got=%0d want=7", i, st_cyc[i] - st_cyc[i-1]);
      end
    end
    checks += 2;
    if (done_cyc - st_cyc[7] != 7) begin failures++; $display("FAIL full_done_lat got=%0d want=7", done_cyc - st_cyc[7]); end
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL full_busy_done got=%b want=1", bus.busy); end
    bus.en = 1'b1;
    @(negedge clock);
    bus.en = 1'b0;
    repeat (2) begin
      @(negedge clock);
      checks++;
      if (bus.busy !== 1'b0 || bus.phase_start !== 8'h00) begin
        failures++; $display("FAIL finish_en_ignored got busy=%b start=%b want busy=0 start=0", bus.busy, bus.phase_start);
      end
    end
  endtask

  task automatic test_skip();
    grant_seen = 8'h00;
    push_model(8'b1000_0101);
    run_en(8'b1000_0101);
    wait_done(100);
    checks++;
    if (grant_seen !== 8'b1000_0101) begin failures++; $display("FAIL skip_grants got=%b want=10000101", grant_seen); end
  endtask

  task automatic test_empty();
    grant_seen = 8'h00;
    start_seen = 8'h00;
    push_model(8'h00);
    run_en(8'h00);
    wait_done(5);
    checks += 2;
    if (done_cyc != e_cyc) begin failures++; $display("FAIL empty_done_lat got=%0d want=%0d", done_cyc, e_cyc); end
    if ({grant_seen, start_seen} !== 16'h0) begin
      failures++; $display("FAIL empty_quiet got grant=%b start=%b want=0", grant_seen, start_seen);
    end
  endtask

  task automatic test_isolation();
    a[3] = 11'h0C8; w[3] = 1'b1; d[3] = 16'h1234;
    a[5] = 11'h555; w[5] = 1'b1; d[5] = 16'hBEEF;
    push_model(8'h48);
    run_en(8'h48);
    wait_grant(8'h08);
    checks++;
    if (bus.address !== 11'h0C8 || bus.wr_en !== 1'b1 || bus.mem_data_in !== 16'h1234) begin
      failures++;
      $display("FAIL iso_port got addr=%h wr=%b data=%h want addr=0c8 wr=1 data=1234", bus.address, bus.wr_en, bus.mem_data_in);
    end
    wait_done(100);
    w = 8'h00;
  endtask

  task automatic test_stray_and_reset();
    push_model(8'h54);
    run_en(8'h54);
    wait_grant(8'h04);
    stray_done = 8'h40;
    repeat (2) @(negedge clock);
    stray_done = 8'h00;
    bus.phase_mask = 8'hFF;
    bus.en = 1'b1;
    @(negedge clock);
    bus.en = 1'b0;
    checks++;
    if (bus.grant !== 8'h04 || bus.cur_phase !== 3'd2) begin
      failures++; $display("FAIL stray_hold got grant=%b cur=%0d want grant=00000100 cur=2", bus.grant, bus.cur_phase);
    end
    wait_grant(8'h10);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({bus.grant, bus.phase_start, bus.busy, bus.cur_phase} !== 20'h0 || {bus.address, bus.wr_en, bus.mem_data_in} !== 28'h0) begin
      failures++;
      $display("FAIL async_reset got grant=%b busy=%b cur=%0d addr=%h want all 0", bus.grant, bus.busy, bus.cur_phase, bus.address);
    end
    exp_q.delete();
    @(negedge clock);
    nrst = 1'b1;
    push_model(8'h54);
    run_en(8'h54);
    checks++;
    if (st_cyc[2] != e_cyc) begin failures++; $display("FAIL restart_first got=%0d want=%0d", st_cyc[2], e_cyc); end
    wait_done(100);
  endtask

`ifdef PHASE_TIMEOUT_EN
  task automatic test_watchdog();
    int n, t;
    n = 0;
    hang = 8'h02;
    push_model(8'h06);
    run_en(8'h06);
    while (bus.timeout_err !== 1'b1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    t = cyc;
    checks++;
    if (bus.timeout_err !== 1'b1 || t - st_cyc[1] != 16) begin
      failures++; $display("FAIL wd_rise got err=%b lat=%0d want err=1 lat=16", bus.timeout_err, t - st_cyc[1]);
    end
    wait_done(60);
    checks += 2;
    if (st_cyc[2] - t != 2) begin failures++; $display("FAIL wd_next got=%0d want=2", st_cyc[2] - t); end
    if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL wd_sticky got=%b want=1", bus.timeout_err); end
    hang = 8'h00;
    push_model(8'h01);
    run_en(8'h01);
    checks++;
    if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL wd_clear got=%b want=0", bus.timeout_err); end
    wait_done(40);
  endtask
`endif

  initial begin
    bus.en = 1'b0;
    bus.phase_mask = 8'h00;
    w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      a[i] = 11'(i * 16 + 1);
      d[i] = 16'(16'hA000 + i);
      st_cyc[i] = 0;
    end
    test_reset();
    test_full_run();
    test_skip();
    test_empty();
    test_isolation();
    test_stray_and_reset();
`ifdef PHASE_TIMEOUT_EN
    test_watchdog();
`endif
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
